ifmap_writer: RTL and testbench

IFMAP_WRITER -- requirements
Module: ifmap_writer

---
 rtl/ifmap_writer.sv | 165 ++++++++++++++++
 tb/tb_ifmap_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_writer.sv
// Input-feature-map row writer: streams upstream words into a row scratchpad and
// hands complete rows to a consumer. Define IFMAP_WRITER_DBLBUF_EN for two ping-pong banks.
module ifmap_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   row_len,
    input  logic [7:0]        num_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              spad_wen,
`ifdef IFMAP_WRITER_DBLBUF_EN
    output logic [ADDR_W:0]   spad_waddr,
`else
    output logic [ADDR_W-1:0] spad_waddr,
`endif
    output logic [DATA_W-1:0] spad_wdata,
    output logic              av_data,
    output logic              rd_bank,
    input  logic              next_row,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        nrows_q, nrows_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]        loaded_q, loaded_d;
    logic [7:0]        released_q, released_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              done_q, done_d;

    logic              ready_raw, transfer, release_row, row_last, more_rows;
    logic [ADDR_W:0]   len_m1, len_sat;
    logic [7:0]        released_inc;

    // Any length above the bank depth means "one full bank".
    assign len_sat      = row_len[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : row_len;
    assign len_m1       = len_q - 1'b1;
    assign row_last     = ({1'b0, wcnt_q} == len_m1);
    assign more_rows    = (loaded_q < nrows_q);
    assign released_inc = released_q + 8'd1;

`ifdef IFMAP_WRITER_DBLBUF_EN
    assign ready_raw = (state_q == S_FILL) && !full_q[wr_bank_q] && more_rows;
`else
    assign ready_raw = (state_q == S_FILL) && more_rows;
`endif

    // Outputs are forced low while rst is high, before the registers have cleared.
    assign in_ready    = ready_raw && !rst;
    assign transfer    = in_valid && in_ready;
    assign av_data     = full_q[rd_bank_q] && !rst;
    assign release_row = next_row && av_data;

    assign spad_wen   = transfer;
    assign spad_wdata = transfer ? in_data : '0;
`ifdef IFMAP_WRITER_DBLBUF_EN
    assign spad_waddr = rst ? '0 : {wr_bank_q, wcnt_q};
`else
    assign spad_waddr = rst ? '0 : wcnt_q;
`endif
    assign rd_bank = rd_bank_q;
    assign busy    = (state_q != S_IDLE) && !rst;
    assign done    = done_q && !rst;

    always_comb begin
        // NOTE: every next-state value defaults to its current value so no path infers a latch.
        state_d    = state_q;
        len_d      = len_q;
        nrows_d    = nrows_q;
        wcnt_d     = wcnt_q;
        loaded_d   = loaded_q;
        released_d = released_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (row_len != '0) && (num_rows != '0)) begin
                    len_d      = len_sat;
                    nrows_d    = num_rows;
                    wcnt_d     = '0;
                    loaded_d   = '0;
                    released_d = '0;
                    full_d     = '0;
                    wr_bank_d  = 1'b0;
                    rd_bank_d  = 1'b0;
                    state_d    = S_FILL;
                end
            end
            default: begin
                if (transfer) begin
                    if (row_last) begin
                        wcnt_d            = '0;
                        loaded_d          = loaded_q + 8'd1;
                        full_d[wr_bank_q] = 1'b1;
`ifdef IFMAP_WRITER_DBLBUF_EN
                        wr_bank_d = ~wr_bank_q;
`else
                        state_d   = S_HOLD;
`endif
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                // Fill and release always target different banks, so both may apply at once.
                if (release_row) begin
                    full_d[rd_bank_q] = 1'b0;
                    released_d        = released_inc;
`ifdef IFMAP_WRITER_DBLBUF_EN
                    rd_bank_d = ~rd_bank_q;
`endif
                    if (released_inc == nrows_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
`ifndef IFMAP_WRITER_DBLBUF_EN
                        state_d = S_FILL;
`endif
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            nrows_q    <= '0;
            wcnt_q     <= '0;
            loaded_q   <= '0;
            released_q <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            nrows_q    <= nrows_d;
            wcnt_q     <= wcnt_d;
            loaded_q   <= loaded_d;
            released_q <= released_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ifmap_writer.sv
// Directed self-checking bench for ifmap_writer; double-buffer scenarios run
// only when IFMAP_WRITER_DBLBUF_EN is defined for the build.
module tb_ifmap_writer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
`ifdef IFMAP_WRITER_DBLBUF_EN
    localparam int WA = ADDR_W + 1;
`else
    localparam int WA = ADDR_W;
`endif

    logic              clk = 1'b0;
    logic              rst, start, in_valid, next_row;
    logic [ADDR_W:0]   row_len;
    logic [7:0]        num_rows;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, spad_wen, av_data, rd_bank, busy, done;
    logic [WA-1:0]     spad_waddr;
    logic [DATA_W-1:0] spad_wdata;

    int errors = 0;
    int checks = 0;

    ifmap_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .spad_wen(spad_wen),
        .spad_waddr(spad_waddr), .spad_wdata(spad_wdata), .av_data(av_data),
        .rd_bank(rd_bank), .next_row(next_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; row_len = 5'd3; num_rows = 8'd1;
        in_valid = 1'b1; in_data = 16'hBEEF; next_row = 1'b1;
        tick; tick; settle;
        checks++;
        if ({in_ready, spad_wen, av_data, busy, done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, spad_wen, av_data, busy, done});
        end
        checks++;
        if (spad_waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", spad_waddr); end
        checks++;
        if (spad_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", spad_wdata); end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; next_row = 1'b0;
        tick; settle;
        checks++;
        if ({in_ready, av_data, busy, done} !== 4'b0) begin
            errors++; $display("FAIL after_reset: got %b expected 0000", {in_ready, av_data, busy, done});
        end
    endtask

    task automatic test_zero_start;
        row_len = 5'd0; num_rows = 8'd1; start = 1'b1;
        tick; start = 1'b0; settle;
        checks++;
        if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL zero_len: got %b expected 00", {busy, in_ready}); end
        row_len = 5'd3; num_rows = 8'd0; start = 1'b1;
        tick; start = 1'b0; settle;
        checks++;
        if ({busy, in_ready} !== 2'b00) begin errors++; $display("FAIL zero_rows: got %b expected 00", {busy, in_ready}); end
    endtask

    task automatic test_single_row;
        row_len = 5'd3; num_rows = 8'd1; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1;
        next_row = 1'b1;  // no row is available yet, so this must be ignored
        for (int i = 0; i < 3; i++) begin
            in_data = 16'hA000 + 16'(i);
            settle;
            checks++;
            if ({spad_wen, in_ready, busy} !== 3'b111) begin
                errors++; $display("FAIL single_ctrl%0d: got %b expected 111", i, {spad_wen, in_ready, busy});
            end
            checks++;
            if (spad_waddr !== WA'(i)) begin errors++; $display("FAIL single_addr%0d: got %0d expected %0d", i, spad_waddr, i); end
            checks++;
            if (spad_wdata !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL single_data%0d: got %0h expected %0h", i, spad_wdata, 16'hA000 + 16'(i));
            end
            tick;
            next_row = 1'b0;
        end
        settle;
        checks++;
        if ({av_data, in_ready, spad_wen, busy, done} !== 5'b10010) begin
            errors++; $display("FAIL single_hold: got %b expected 10010", {av_data, in_ready, spad_wen, busy, done});
        end
        row_len = 5'd5; start = 1'b1;
        tick; start = 1'b0; settle;
        checks++;
        if ({av_data, in_ready, busy} !== 3'b101) begin
            errors++; $display("FAIL start_in_hold: got %b expected 101", {av_data, in_ready, busy});
        end
        in_valid = 1'b0; next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if ({done, busy, av_data} !== 3'b100) begin
            errors++; $display("FAIL single_done: got %b expected 100", {done, busy, av_data});
        end
        tick; settle;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_saturate;
        row_len = 5'd20; num_rows = 8'd1; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 16'(100 + i);
            settle;
            checks++;
            if (spad_wen !== 1'b1 || spad_waddr !== WA'(i)) begin
                errors++; $display("FAIL sat_word%0d: got wen=%b addr=%0d expected wen=1 addr=%0d", i, spad_wen, spad_waddr, i);
            end
            tick;
        end
        settle;
        checks++;
        if ({av_data, in_ready} !== 2'b10) begin errors++; $display("FAIL sat_full: got %b expected 10", {av_data, in_ready}); end
        in_valid = 1'b0; next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL sat_done: got %b expected 10", {done, busy}); end
        tick;
    endtask

    task automatic test_back_to_back;
        row_len = 5'd2; num_rows = 8'd2; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        settle;
        checks++;
        if (spad_wen !== 1'b1 || spad_waddr !== WA'(0)) begin
            errors++; $display("FAIL b2b_w0: got wen=%b addr=%0d expected wen=1 addr=0", spad_wen, spad_waddr);
        end
        tick; in_valid = 1'b0; settle;
        checks++;
        if ({spad_wen, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle_valid: got %b expected 01", {spad_wen, in_ready}); end
        tick; in_valid = 1'b1; in_data = 16'h0022; settle;
        checks++;
        if (spad_wen !== 1'b1 || spad_waddr !== WA'(1)) begin
            errors++; $display("FAIL b2b_w1: got wen=%b addr=%0d expected wen=1 addr=1", spad_wen, spad_waddr);
        end
        tick; in_data = 16'h0033; settle;
        checks++;
        if ({in_ready, spad_wen, av_data} !== 3'b001) begin
            errors++; $display("FAIL b2b_hold: got %b expected 001", {in_ready, spad_wen, av_data});
        end
        next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if ({done, busy, av_data, in_ready, spad_wen} !== 5'b01011 || spad_waddr !== WA'(0)) begin
            errors++; $display("FAIL b2b_row2: got %b addr=%0d expected 01011 addr=0",
                               {done, busy, av_data, in_ready, spad_wen}, spad_waddr);
        end
        tick; in_data = 16'h0044; settle;
        checks++;
        if (spad_waddr !== WA'(1) || spad_wdata !== 16'h0044) begin
            errors++; $display("FAIL b2b_w3: got addr=%0d data=%0h expected addr=1 data=44", spad_waddr, spad_wdata);
        end
        tick; in_valid = 1'b0; settle;
        checks++;
        if (av_data !== 1'b1) begin errors++; $display("FAIL b2b_av2: got %b expected 1", av_data); end
        next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done: got %b expected 10", {done, busy}); end
        tick;
    endtask

    task automatic test_reset_mid_row;
        row_len = 5'd4; num_rows = 8'd1; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1; in_data = 16'h5555;
        tick; tick;
        rst = 1'b1; settle;
        checks++;
        if ({spad_wen, in_ready, busy} !== 3'b000) begin
            errors++; $display("FAIL rst_during: got %b expected 000", {spad_wen, in_ready, busy});
        end
        tick; settle;
        checks++;
        if ({in_ready, spad_wen, av_data, busy, done} !== 5'b0 || spad_waddr !== '0 || spad_wdata !== '0) begin
            errors++; $display("FAIL rst_mid: got %b addr=%0d data=%0h expected 00000 addr=0 data=0",
                               {in_ready, spad_wen, av_data, busy, done}, spad_waddr, spad_wdata);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick; settle;
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rst_no_done: got %b expected 00", {done, busy}); end
        row_len = 5'd2; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1; settle;
        checks++;
        if (spad_wen !== 1'b1 || spad_waddr !== WA'(0)) begin
            errors++; $display("FAIL rst_restart: got wen=%b addr=%0d expected wen=1 addr=0", spad_wen, spad_waddr);
        end
        tick; tick; in_valid = 1'b0; next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL rst_restart_done: got %b expected 1", done); end
        tick;
    endtask

`ifdef IFMAP_WRITER_DBLBUF_EN
    task automatic test_dblbuf;
        logic [WA-1:0] exp_addr [4];
        exp_addr[0] = 5'd0; exp_addr[1] = 5'd1; exp_addr[2] = 5'd16; exp_addr[3] = 5'd17;
        row_len = 5'd2; num_rows = 8'd3; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle;
            checks++;
            if (spad_wen !== 1'b1 || spad_waddr !== exp_addr[i]) begin
                errors++; $display("FAIL dbl_addr%0d: got wen=%b addr=%0d expected wen=1 addr=%0d", i, spad_wen, spad_waddr, exp_addr[i]);
            end
            tick;
        end
        settle;
        checks++;
        if ({in_ready, av_data, rd_bank} !== 3'b010) begin errors++; $display("FAIL dbl_both_full: got %b expected 010", {in_ready, av_data, rd_bank}); end
        next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if ({rd_bank, av_data, in_ready} !== 3'b111 || spad_waddr !== 5'd0) begin
            errors++; $display("FAIL dbl_release0: got %b addr=%0d expected 111 addr=0", {rd_bank, av_data, in_ready}, spad_waddr);
        end
        tick; settle;
        checks++;
        if (spad_wen !== 1'b1 || spad_waddr !== 5'd1) begin
            errors++; $display("FAIL dbl_row3: got wen=%b addr=%0d expected wen=1 addr=1", spad_wen, spad_waddr);
        end
        tick; settle;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL dbl_all_loaded: got %b expected 0", in_ready); end
        in_valid = 1'b0; next_row = 1'b1;
        tick; settle;
        checks++;
        if ({done, av_data, rd_bank} !== 3'b010) begin errors++; $display("FAIL dbl_release1: got %b expected 010", {done, av_data, rd_bank}); end
        tick; next_row = 1'b0; settle;
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL dbl_done: got %b expected 10", {done, busy}); end
        tick;
    endtask

    task automatic test_simultaneous;
        row_len = 5'd2; num_rows = 8'd2; start = 1'b1;
        tick; start = 1'b0; in_valid = 1'b1;
        tick; tick; tick;
        next_row = 1'b1; settle;
        checks++;
        if ({spad_wen, av_data} !== 2'b11 || spad_waddr !== 5'd17) begin
            errors++; $display("FAIL simul_pre: got %b addr=%0d expected 11 addr=17", {spad_wen, av_data}, spad_waddr);
        end
        tick; next_row = 1'b0; in_valid = 1'b0; settle;
        checks++;
        if ({rd_bank, av_data, in_ready, busy} !== 4'b1101) begin
            errors++; $display("FAIL simul_post: got %b expected 1101", {rd_bank, av_data, in_ready, busy});
        end
        next_row = 1'b1;
        tick; next_row = 1'b0; settle;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL simul_done: got %b expected 1", done); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_zero_start;
        test_single_row;
        test_saturate;
        test_back_to_back;
        test_reset_mid_row;
`ifdef IFMAP_WRITER_DBLBUF_EN
        test_dblbuf;
        test_simultaneous;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
